// File: rtl/teleport_ctrl.sv
// Frame-paced teleport sequencer: hide, relocate, reveal, cooldown for Bumpy.
// Define TELEPORT_BLINK_EN to make Bumpy blink at frame rate during the fades.
module teleport_ctrl #(
    parameter int NUM_OF_COLS     = 10,
    parameter int NUM_OF_ROWS     = 7,
    parameter int TILE_SHIFT      = 6,
    parameter int DEST_OFFSET_X   = 20,
    parameter int DEST_OFFSET_Y   = 20,
    parameter int FADE_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision_tport,
    input  logic [7:0]  teleport_cordinates,
    output logic        teleport_load,
    output logic [10:0] destX,
    output logic [10:0] destY,
    output logic        hide_bumpy,
    output logic        busy,
    output logic        bad_dest
);

    localparam int CNT_MAX = (FADE_FRAMES > COOLDOWN_FRAMES) ? FADE_FRAMES : COOLDOWN_FRAMES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] FADE_LAST = CW'(FADE_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        JUMP,
        FADE_IN,
        COOLDOWN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          capture, reject;
    logic          load_n, busy_n, hide_n;

    logic [3:0]    xi, yi;
    logic          dest_ok;
    logic [10:0]   pix_x, pix_y;

    assign xi      = teleport_cordinates[7:4];
    assign yi      = teleport_cordinates[3:0];
    assign dest_ok = (int'(xi) < NUM_OF_COLS) && (int'(yi) < NUM_OF_ROWS);
    // Pixel arithmetic deliberately wraps at 11 bits.
    assign pix_x   = (11'(xi) << TILE_SHIFT) + 11'(DEST_OFFSET_X);
    assign pix_y   = (11'(yi) << TILE_SHIFT) + 11'(DEST_OFFSET_Y);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        reject  = 1'b0;

        case (state)
            IDLE: begin
                if (collision_tport) begin
                    if (dest_ok) begin
                        capture = 1'b1;
                        state_n = FADE_OUT;
                        cnt_n   = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FADE_OUT: begin
                if (startOfFrame) begin
                    if (cnt == FADE_LAST) begin
                        state_n = JUMP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            JUMP: begin
                state_n = FADE_IN;
                cnt_n   = '0;
            end
            FADE_IN: begin
                if (startOfFrame) begin
                    if (cnt == FADE_LAST) begin
                        state_n = COOLDOWN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    if (cnt == COOL_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        load_n = (state_n == JUMP);
        busy_n = (state_n != IDLE);
        hide_n = 1'b0;
        case (state_n)
            FADE_OUT, FADE_IN: begin
`ifdef TELEPORT_BLINK_EN
                hide_n = cnt_n[0];
`else
                hide_n = 1'b1;
`endif
            end
            JUMP:    hide_n = 1'b1;
            default: hide_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (resetN) begin
            state         <= IDLE;
            cnt           <= '0;
            teleport_load <= 1'b0;
            destX         <= '0;
            destY         <= '0;
            hide_bumpy    <= 1'b0;
            busy          <= 1'b0;
            bad_dest      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            teleport_load <= load_n;
            hide_bumpy    <= hide_n;
            busy          <= busy_n;
            if (capture) begin
                destX <= pix_x;
                destY <= pix_y;
            end
            if (reject) begin
                bad_dest <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_teleport_ctrl.sv
// Scoreboard bench for teleport_ctrl: stimulus queues expected destinations,
// a monitor pops and compares them whenever the DUT strobes teleport_load.
module tb_teleport_ctrl;

    localparam int FF = 8;
    localparam int CF = 30;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        collision_tport;
    logic [7:0]  teleport_cordinates;
    logic        teleport_load;
    logic [10:0] destX;
    logic [10:0] destY;
    logic        hide_bumpy;
    logic        busy;
    logic        bad_dest;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } dest_t;

    dest_t sb[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    n_loads  = 0;

    teleport_ctrl #(
        .NUM_OF_COLS(10), .NUM_OF_ROWS(7), .TILE_SHIFT(6),
        .DEST_OFFSET_X(20), .DEST_OFFSET_Y(20),
        .FADE_FRAMES(FF), .COOLDOWN_FRAMES(CF)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .collision_tport    (collision_tport),
        .teleport_cordinates(teleport_cordinates),
        .teleport_load      (teleport_load),
        .destX              (destX),
        .destY              (destY),
        .hide_bumpy         (hide_bumpy),
        .busy               (busy),
        .bad_dest           (bad_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_hide(input int c);
`ifdef TELEPORT_BLINK_EN
        return (c % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: every load strobe must match the oldest queued destination.
    always @(negedge clk) begin
        if (teleport_load === 1'b1) begin
            n_loads++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_load: got load with destX=%0d destY=%0d, expected none", destX, destY);
            end else begin
                dest_t e;
                e = sb.pop_front();
                check("load_destX", 32'(destX), 32'(e.x));
                check("load_destY", 32'(destY), 32'(e.y));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture a destination from IDLE, optionally coinciding with startOfFrame.
    task automatic capture(input logic [7:0] coords, input logic [10:0] ex, input logic [10:0] ey,
                           input logic with_sof);
        dest_t e;
        collision_tport     = 1'b1;
        teleport_cordinates = coords;
        startOfFrame        = with_sof;
        e.x = ex;
        e.y = ey;
        sb.push_back(e);
        step();
        collision_tport = 1'b0;
        startOfFrame    = 1'b0;
        check("cap_destX", 32'(destX), 32'(ex));
        check("cap_destY", 32'(destY), 32'(ey));
        check("cap_busy", 32'(busy), 1);
        check("cap_hide", 32'(hide_bumpy), 32'(exp_hide(0)));
        check("cap_load", 32'(teleport_load), 0);
    endtask

    task automatic fade_out_jump(input logic sof_in_jump);
        int loads0;
        loads0 = n_loads;
        for (int k = 1; k <= FF; k++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            if (k < FF) begin
                check("fo_hide", 32'(hide_bumpy), 32'(exp_hide(k)));
                check("fo_load", 32'(teleport_load), 0);
            end else begin
                check("jump_load", 32'(teleport_load), 1);
                check("jump_hide", 32'(hide_bumpy), 1);
                startOfFrame = sof_in_jump;
            end
            step();
            startOfFrame = 1'b0;
            if (k == FF) begin
                check("fi0_load", 32'(teleport_load), 0);
                check("fi0_hide", 32'(hide_bumpy), 32'(exp_hide(0)));
            end
            step();
        end
        check("one_load", 32'(n_loads - loads0), 1);
    endtask

    task automatic fade_in(input int pulses);
        for (int k = 1; k <= pulses; k++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            if (k < FF) begin
                check("fi_hide", 32'(hide_bumpy), 32'(exp_hide(k)));
                check("fi_busy", 32'(busy), 1);
            end else begin
                check("cd_hide", 32'(hide_bumpy), 0);
                check("cd_busy", 32'(busy), 1);
            end
            step();
            step();
        end
    endtask

    task automatic cooldown(input logic with_coll, input logic [10:0] held_x);
        for (int k = 1; k <= CF; k++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            if (k < CF) begin
                collision_tport     = with_coll;
                teleport_cordinates = 8'h03;
                step();
                collision_tport = 1'b0;
                check("cd_busy", 32'(busy), 1);
                check("cd_hold_destX", 32'(destX), 32'(held_x));
            end else begin
                check("idle_busy", 32'(busy), 0);
                check("idle_hide", 32'(hide_bumpy), 0);
            end
            step();
        end
    endtask

    initial begin
        resetN              = 1'b1;
        startOfFrame        = 1'b0;
        collision_tport     = 1'b0;
        teleport_cordinates = 8'h00;
        step();
        step();
        resetN = 1'b0;
        check("rst_load", 32'(teleport_load), 0);
        check("rst_destX", 32'(destX), 0);
        check("rst_destY", 32'(destY), 0);
        check("rst_hide", 32'(hide_bumpy), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bad", 32'(bad_dest), 0);
        step();

        // Invalid destinations: X index 10, Y index 9, Y index 7.
        collision_tport = 1'b1;
        teleport_cordinates = 8'hA2;
        step();
        collision_tport = 1'b0;
        check("bad_x_flag", 32'(bad_dest), 1);
        check("bad_x_busy", 32'(busy), 0);
        step();
        collision_tport = 1'b1;
        teleport_cordinates = 8'h09;
        step();
        collision_tport = 1'b1;
        teleport_cordinates = 8'h07;
        step();
        collision_tport = 1'b0;
        check("bad_y_busy", 32'(busy), 0);
        check("bad_y_flag", 32'(bad_dest), 1);
        check("bad_destX", 32'(destX), 0);
        step();

        // Capture together with startOfFrame; that pulse must not count. SOF in JUMP also ignored.
        capture(8'h16, 11'd84, 11'd404, 1'b1);
        fade_out_jump(1'b1);
        fade_in(FF);
        cooldown(1'b0, 11'd84);
        check("seq1_bad_sticky", 32'(bad_dest), 1);

        // Collision held for 50 cycles: a single capture.
        capture(8'h76, 11'd468, 11'd404, 1'b0);
        collision_tport = 1'b1;
        teleport_cordinates = 8'h16;
        for (int i = 0; i < 49; i++) step();
        collision_tport = 1'b0;
        check("hold_destX", 32'(destX), 468);
        check("hold_busy", 32'(busy), 1);
        fade_out_jump(1'b0);
        fade_in(3);

        // Reset in the middle of FADE_IN.
        resetN = 1'b1;
        step();
        resetN = 1'b0;
        check("mid_rst_load", 32'(teleport_load), 0);
        check("mid_rst_destX", 32'(destX), 0);
        check("mid_rst_destY", 32'(destY), 0);
        check("mid_rst_hide", 32'(hide_bumpy), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_bad", 32'(bad_dest), 0);
        step();

        // Collisions every frame through COOLDOWN are ignored; first one after is captured.
        capture(8'h90, 11'd596, 11'd20, 1'b0);
        fade_out_jump(1'b0);
        fade_in(FF);
        cooldown(1'b1, 11'd596);
        capture(8'h96, 11'd596, 11'd404, 1'b0);
        fade_out_jump(1'b0);
        fade_in(FF);
        cooldown(1'b0, 11'd596);

        step();
        step();
        check("sb_empty", 32'(sb.size()), 0);
        check("load_total", 32'(n_loads), 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
